// File: rtl/random_point_sampler_pkg.sv
// random_point_sampler_pkg: screen geometry defaults, coordinate widths and sampler states
package random_point_sampler_pkg;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int unsigned H_MAX_DEF = 640;
  localparam int unsigned V_MAX_DEF = 480;
  typedef enum logic [2:0] {
    S_UNSEEDED = 3'd0,
    S_ARM      = 3'd1,
    S_SETTLE   = 3'd2,
    S_IDLE     = 3'd3,
    S_SAMPLE   = 3'd4,
    S_VALID    = 3'd5
  } state_t;
endpackage

// File: rtl/random_point_sampler_grid_point_check.sv
// random_point_sampler_grid_point_check: snaps a candidate to the grid and tests range and repeat
// ports: i_x/i_y raw candidate, i_prev_valid/i_prev_x/i_prev_y last point,
//        o_ax/o_ay grid-aligned candidate, o_ok candidate acceptable
module random_point_sampler_grid_point_check
  import random_point_sampler_pkg::*;
#(
  parameter int unsigned H_MAX = H_MAX_DEF,
  parameter int unsigned V_MAX = V_MAX_DEF,
  parameter int unsigned SIZE  = 16
) (
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic          i_prev_valid,
  input  logic [XW-1:0] i_prev_x,
  input  logic [YW-1:0] i_prev_y,
  output logic [XW-1:0] o_ax,
  output logic [YW-1:0] o_ay,
  output logic          o_ok
);
  localparam logic [XW-1:0] X_LIM = XW'(H_MAX - SIZE);
  localparam logic [YW-1:0] Y_LIM = YW'(V_MAX - SIZE);
  assign o_ax = i_x & ~XW'(SIZE - 1);
  assign o_ay = i_y & ~YW'(SIZE - 1);
  assign o_ok = (o_ax <= X_LIM) && (o_ay <= Y_LIM) &&
                !(i_prev_valid && o_ax == i_prev_x && o_ay == i_prev_y);
endmodule

// File: rtl/random_point_sampler.sv
// random_point_sampler: seeds random_generator and hands out grid-aligned on-screen points
// ports: i_clk/i_rst_n clock and async active-low reset, i_req point request,
//        i_rand_x/i_rand_y generator outputs, o_gen_init/o_gen_seed generator control,
//        o_busy searching, o_pt_valid/i_pt_ack point handshake,
//        o_pt_x/o_pt_y/o_pt_fallback presented point
module random_point_sampler
  import random_point_sampler_pkg::*;
#(
  parameter int unsigned H_MAX         = 640,
  parameter int unsigned V_MAX         = 480,
  parameter int unsigned SIZE          = 16,
  parameter int unsigned MAX_TRIES     = 15,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FALLBACK_X    = 320,
  parameter int unsigned FALLBACK_Y    = 240
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic [XW-1:0] i_rand_x,
  input  logic [YW-1:0] i_rand_y,
  output logic          o_gen_init,
  output logic [3:0]    o_gen_seed,
  output logic          o_busy,
  output logic          o_pt_valid,
  input  logic          i_pt_ack,
  output logic [XW-1:0] o_pt_x,
  output logic [YW-1:0] o_pt_y,
  output logic          o_pt_fallback
);
  state_t          r_state, w_next;
  logic [3:0]      r_seed_cnt, r_gen_seed, r_settle;
  logic [7:0]      r_tries;
  logic            r_gen_init, r_prev_valid, r_fb;
  logic [XW-1:0]   r_pt_x, w_ax;
  logic [YW-1:0]   r_pt_y, w_ay;
  logic            w_ok, w_last;

  random_point_sampler_grid_point_check #(.H_MAX(H_MAX), .V_MAX(V_MAX), .SIZE(SIZE)) u_check (
    .i_x(i_rand_x), .i_y(i_rand_y), .i_prev_valid(r_prev_valid),
    .i_prev_x(r_pt_x), .i_prev_y(r_pt_y), .o_ax(w_ax), .o_ay(w_ay), .o_ok(w_ok)
  );

  // the current sample is the last allowed try; a reject here falls back
  assign w_last        = r_tries == 8'(MAX_TRIES - 1);
  assign o_busy        = r_state inside {S_ARM, S_SETTLE, S_SAMPLE};
  assign o_pt_valid    = r_state == S_VALID;
  assign o_gen_init    = r_gen_init;
  assign o_gen_seed    = r_gen_seed;
  assign o_pt_x        = r_pt_x;
  assign o_pt_y        = r_pt_y;
  assign o_pt_fallback = r_fb;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_UNSEEDED;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_UNSEEDED: w_next = i_req ? S_ARM : S_UNSEEDED;
      S_ARM:      w_next = S_SETTLE;
      S_SETTLE:   w_next = (r_settle == 4'(SETTLE_CYCLES - 1)) ? S_SAMPLE : S_SETTLE;
      S_IDLE:     w_next = i_req ? S_SAMPLE : S_IDLE;
      S_SAMPLE:   w_next = (w_ok || w_last) ? S_VALID : S_SAMPLE;
      S_VALID:    w_next = !i_pt_ack ? S_VALID : i_req ? S_SAMPLE : S_IDLE;
      // an already-seeded generator needs no reseed after a corrupted state
      default:    w_next = r_gen_init ? S_IDLE : S_UNSEEDED;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_seed_cnt   <= '0;
      r_gen_seed   <= '0;
      r_gen_init   <= 1'b0;
      r_settle     <= '0;
      r_tries      <= '0;
      r_prev_valid <= 1'b0;
      r_pt_x       <= '0;
      r_pt_y       <= '0;
      r_fb         <= 1'b0;
    end else begin
      r_seed_cnt <= r_seed_cnt + 4'd1;
      if (r_state == S_UNSEEDED && i_req) r_gen_seed <= r_seed_cnt;
      if (r_state == S_ARM) r_gen_init <= 1'b1;
      r_settle <= (r_state == S_SETTLE) ? r_settle + 4'd1 : 4'd0;
      // tries restart from zero whenever a search is entered from any other state
      r_tries  <= (r_state == S_SAMPLE) ? r_tries + 8'd1 : 8'd0;
      if (r_state == S_SAMPLE && (w_ok || w_last)) begin
        r_pt_x       <= w_ok ? w_ax : XW'(FALLBACK_X);
        r_pt_y       <= w_ok ? w_ay : YW'(FALLBACK_Y);
        r_fb         <= !w_ok;
        r_prev_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_random_point_sampler.sv
// tb_random_point_sampler: directed table plus randomized searches against a point-selection model
module tb_random_point_sampler;
  localparam int MAX_TRIES = 15;
  localparam int SIZE      = 16;
  localparam int LIM       = MAX_TRIES + 3;

  logic       clk = 1'b0, rst_n = 1'b1, req = 1'b0, ack = 1'b0;
  logic [9:0] rx = '0;
  logic [8:0] ry = '0;
  logic       gen_init, busy, pt_valid, pt_fb;
  logic [3:0] gen_seed;
  logic [9:0] pt_x;
  logic [8:0] pt_y;

  int n_err = 0, n_chk = 0;
  logic [3:0] m_seed;
  bit m_pv = 1'b0;
  int m_px = 0, m_py = 0;
  int cx[16], cy[16];
  int cn = 1;

  typedef struct packed {
    logic [1:0]       mode;
    logic [2:0]       n;
    logic [3:0][9:0]  vx;
    logic [3:0][8:0]  vy;
    logic [9:0]       ex;
    logic [8:0]       ey;
    logic             efb;
    logic [4:0]       ek;
  } vec_t;
  vec_t tbl[8];

  random_point_sampler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_rand_x(rx), .i_rand_y(ry),
    .o_gen_init(gen_init), .o_gen_seed(gen_seed), .o_busy(busy), .o_pt_valid(pt_valid),
    .i_pt_ack(ack), .o_pt_x(pt_x), .o_pt_y(pt_y), .o_pt_fallback(pt_fb)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_seed <= '0;
    else        m_seed <= m_seed + 4'd1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int mode, input int n,
                         input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input int x3, input int y3,
                         input int ex, input int ey, input int efb, input int ek);
    tbl[i].mode = 2'(mode); tbl[i].n = 3'(n);
    tbl[i].vx[0] = 10'(x0); tbl[i].vy[0] = 9'(y0);
    tbl[i].vx[1] = 10'(x1); tbl[i].vy[1] = 9'(y1);
    tbl[i].vx[2] = 10'(x2); tbl[i].vy[2] = 9'(y2);
    tbl[i].vx[3] = 10'(x3); tbl[i].vy[3] = 9'(y3);
    tbl[i].ex = 10'(ex); tbl[i].ey = 9'(ey); tbl[i].efb = efb[0]; tbl[i].ek = 5'(ek);
  endtask

  // first acceptable candidate within MAX_TRIES wins, otherwise the fixed fallback point
  task automatic predict(output int ex, output int ey, output int efb, output int ek);
    ek = -1; ex = 320; ey = 240; efb = 1;
    for (int k = 0; k < MAX_TRIES; k++) begin
      int j, ax, ay;
      j  = (k < cn) ? k : cn - 1;
      ax = (cx[j] / SIZE) * SIZE;
      ay = (cy[j] / SIZE) * SIZE;
      if (ek < 0 && ax <= 640 - SIZE && ay <= 480 - SIZE && !(m_pv && ax == m_px && ay == m_py)) begin
        ek = k; ex = ax; ey = ay; efb = 0;
      end
    end
    if (ek < 0) ek = MAX_TRIES - 1;
  endtask

  task automatic run_cands(input string nm, input int ex, input int ey, input int efb, input int ek);
    bit got;
    got = 1'b0;
    chk({nm, ".busy"}, int'(busy), 1);
    for (int k = 0; k < LIM; k++) begin
      rx = 10'(cx[(k < cn) ? k : cn - 1]);
      ry = 9'(cy[(k < cn) ? k : cn - 1]);
      step();
      if (pt_valid) begin
        chk({nm, ".latency"}, k, ek);
        chk({nm, ".x"}, int'(pt_x), ex);
        chk({nm, ".y"}, int'(pt_y), ey);
        chk({nm, ".fallback"}, int'(pt_fb), efb);
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL %s.timeout: pt_valid still 0 after %0d cycles", nm, LIM);
    end
    m_pv = 1'b1; m_px = ex; m_py = ey;
  endtask

  // leave VALID either through IDLE (mode 1) or straight back into a search (mode 2)
  task automatic enter(input int mode, input string nm);
    req = 1'b1;
    step();
    req = 1'b0;
    chk({nm, ".hold_valid"}, int'(pt_valid), 1);
    chk({nm, ".hold_x"}, int'(pt_x), m_px);
    if (mode == 1) begin
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk({nm, ".idle_valid"}, int'(pt_valid), 0);
      chk({nm, ".idle_busy"}, int'(busy), 0);
      chk({nm, ".idle_x"}, int'(pt_x), m_px);
      chk({nm, ".idle_y"}, int'(pt_y), m_py);
      req = 1'b1;
      step();
      req = 1'b0;
    end else begin
      ack = 1'b1; req = 1'b1;
      step();
      ack = 1'b0; req = 1'b0;
      chk({nm, ".drop_valid"}, int'(pt_valid), 0);
    end
  endtask

  initial begin
    int ex, ey, efb, ek, s;
    set_vec(0, 0, 1,   37, 479,    0,   0,    0,   0,  0,  0,  32, 464, 0, 0);
    set_vec(1, 1, 2,  645, 200,  100, 200,    0,   0,  0,  0,  96, 192, 0, 1);
    set_vec(2, 2, 1,  100, 200,    0,   0,    0,   0,  0,  0, 320, 240, 1, 14);
    set_vec(3, 1, 1,    0,   0,    0,   0,    0,   0,  0,  0,   0,   0, 0, 0);
    set_vec(4, 2, 1,  639, 479,    0,   0,    0,   0,  0,  0, 624, 464, 0, 0);
    set_vec(5, 1, 4,  640, 100,  100, 480, 1023, 511, 15, 15,   0,   0, 0, 3);
    set_vec(6, 2, 2,    8,   8,  320, 240,    0,   0,  0,  0, 320, 240, 0, 1);
    set_vec(7, 1, 1,  320, 247,    0,   0,    0,   0,  0,  0, 320, 240, 1, 14);

    #2 rst_n = 1'b0;
    req = 1'b1;
    repeat (3) begin
      step();
      chk("reset_outputs", int'({gen_init, gen_seed, busy, pt_valid, pt_x, pt_y, pt_fb}), 0);
    end
    rst_n = 1'b1;
    req = 1'b0;

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      cn = int'(tbl[i].n);
      for (int j = 0; j < 4; j++) begin
        cx[j] = int'(tbl[i].vx[j]);
        cy[j] = int'(tbl[i].vy[j]);
      end
      if (tbl[i].mode == 2'd0) begin
        step();
        chk("unseeded_busy", int'(busy), 0);
        chk("unseeded_init", int'(gen_init), 0);
        repeat (8) step();
        req = 1'b1;
        step();
        req = 1'b0;
        chk("arm_seed", int'(gen_seed), 9);
        chk("arm_init", int'(gen_init), 0);
        chk("arm_busy", int'(busy), 1);
        step();
        chk("settle_init", int'(gen_init), 1);
        step();
        step();
        chk("settle_valid", int'(pt_valid), 0);
      end else begin
        enter(int'(tbl[i].mode), nm);
      end
      run_cands(nm, int'(tbl[i].ex), int'(tbl[i].ey), int'(tbl[i].efb), int'(tbl[i].ek));
    end

    for (int it = 0; it < 24; it++) begin
      cn = 16;
      for (int j = 0; j < 16; j++) begin
        if (it % 6 == 5) begin
          cx[j] = int'($urandom_range(640, 1023)); cy[j] = int'($urandom_range(0, 511));
        end else if ($urandom_range(0, 3) == 0) begin
          cx[j] = m_px + int'($urandom_range(0, 15)); cy[j] = m_py + int'($urandom_range(0, 15));
        end else begin
          cx[j] = int'($urandom_range(0, 1023)); cy[j] = int'($urandom_range(0, 511));
        end
      end
      enter(int'($urandom_range(1, 2)), $sformatf("rnd%0d", it));
      predict(ex, ey, efb, ek);
      run_cands($sformatf("rnd%0d", it), ex, ey, efb, ek);
    end

    ack = 1'b1;
    step();
    ack = 1'b0;
    cn = 1; cx[0] = 1000; cy[0] = 100;
    rx = 10'd1000; ry = 9'd100;
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    step();
    chk("midreset_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_init", int'(gen_init), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_outs", int'({pt_valid, pt_x, pt_y, pt_fb}), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5 + $urandom_range(0, 7)) step();
    s = int'(m_seed);
    req = 1'b1;
    step();
    req = 1'b0;
    chk("reseed_seed", int'(gen_seed), s);
    chk("reseed_init", int'(gen_init), 0);
    step();
    chk("reseed_init_rise", int'(gen_init), 1);
    step();
    step();
    cn = 1; cx[0] = m_px; cy[0] = m_py;
    m_pv = 1'b0;
    run_cands("post_reset", m_px, m_py, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/random_point_sampler.md
Name: random_point_sampler

Overview:
Downstream consumer and controller of random_generator. It drives the generator's init/seed from a free-running counter. On request, it samples the generator's 10-bit x and 9-bit y each cycle, snaps them to a SIZE grid, and rejects points off the 640x480 active area or equal to the previous point. It then presents one accepted point to the game/render logic with a valid/ack handshake.

Parameters:
H_MAX, 640, active width in pixels; accepted x is at most H_MAX-SIZE
V_MAX, 480, active height in lines; accepted y is at most V_MAX-SIZE
SIZE, 16, grid cell size; must be a power of two and at least 2
MAX_TRIES, 15, rejected samples before the fallback point is used (1..255)
SETTLE_CYCLES, 2, cycles waited after gen_init rises before the first sample (1..15)
FALLBACK_X, 320, x used on fallback; grid-aligned
FALLBACK_Y, 240, y used on fallback; grid-aligned

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  request a new point; level sampled each cycle
rand_x  in  10  x from random_generator
rand_y  in  9  y from random_generator
gen_init  out  1  to random_generator init; its rising edge loads the seed
gen_seed  out  4  to random_generator seed
busy  out  1  high in ARM, SETTLE and SAMPLE
pt_valid  out  1  pt_x/pt_y/pt_fallback hold a valid point
pt_ack  in  1  consumer accepts point; effective only while pt_valid=1
pt_x  out  10  accepted point x, grid-aligned
pt_y  out  9  accepted point y, grid-aligned
pt_fallback  out  1  current point came from the fallback path

Behaviour:
- Reset (async, rst_n=0): state=UNSEEDED; seed_cnt=0, gen_seed=0, gen_init=0, busy=0, pt_valid=0, pt_x=0, pt_y=0, pt_fallback=0, tries=0, prev_valid=0. Reset mid-operation aborts everything; gen_init drops, so the next ARM reseeds the generator.
- seed_cnt: 4-bit, increments every cycle out of reset, wraps 15->0.
- UNSEEDED: on req=1, gen_seed<=seed_cnt and go to ARM.
- ARM (1 cycle): gen_init<=1. gen_init then stays 1 until reset. Go to SETTLE with settle counter=0.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE with tries=0.
- IDLE: on req=1, go to SAMPLE with tries=0. No reseed, no settle.
- SAMPLE, one candidate per cycle:
  - ax = rand_x with the low log2(SIZE) bits cleared; ay likewise from rand_y.
  - Accept iff ax <= H_MAX-SIZE, ay <= V_MAX-SIZE, and !(prev_valid && ax==pt_x && ay==pt_y). Comparisons are unsigned at full port width.
  - On accept: pt_x<=ax, pt_y<=ay, pt_fallback<=0, prev_valid<=1, go to VALID.
  - On reject: tries<=tries+1. If that reject is the MAX_TRIES-th, load pt_x<=FALLBACK_X, pt_y<=FALLBACK_Y, pt_fallback<=1, prev_valid<=1, go to VALID.
  - The fallback is used even if it equals the previous point.
- VALID: pt_valid=1; outputs stable.
  - pt_ack=1 with req=0: go to IDLE; pt_valid falls on the next edge.
  - pt_ack=1 with req=1: go directly to SAMPLE with tries=0.
  - req without pt_ack is ignored.
- Latency: req seen at edge n in IDLE puts the block in SAMPLE at n+1. If that candidate is accepted, pt_valid=1 after edge n+2. From UNSEEDED, add 1 (ARM) + SETTLE_CYCLES.
- Worst case from IDLE: pt_valid by edge n+1+MAX_TRIES.
- req deasserted mid-SAMPLE does not abort the search.
- pt_x/pt_y hold their last value outside VALID and are never cleared except by reset.
- Unused state encodings recover to IDLE if gen_init=1, else to UNSEEDED.

Decomposition:
- Shared header screen_defs: H_MAX/V_MAX defaults, x/y widths (10/9), and the state encodings (UNSEEDED, ARM, SETTLE, IDLE, SAMPLE, VALID).
- One sub-module, grid_point_check: combinational alignment, range test and repeat test, outputs ax, ay, ok. Unit-testable on its own.
- The FSM, counters and output registers stay in random_point_sampler.
- Directed cases drive rand_x/rand_y from the bench in place of random_generator. One integration case instantiates the real generator.

Test Plan:
- Reset: hold rst_n=0 with req=1, then release. All outputs are 0 during reset, and the state stays UNSEEDED until req is sampled after release.
- First request: seed_cnt=9 when req is seen, so gen_seed=9. gen_init rises 1 cycle later, followed by 2 settle cycles. rand_x=37, rand_y=479 gives pt_x=32, pt_y=464, pt_valid=1, pt_fallback=0.
- Range reject: rand_x=645 (ax=640>624) on the first cycle, then 100/200. Result is pt_x=96, pt_y=192, with pt_valid one cycle later than the no-reject case.
- Repeat and fallback: after point (96,192), hold rand_x=100, rand_y=200. The bench sees 15 rejects, then pt_x=320, pt_y=240, pt_fallback=1, pt_valid at edge n+16.
- Handshake: in VALID, req alone keeps the point unchanged. pt_ack+req gives pt_valid=0 next cycle and a new point. pt_ack alone returns to IDLE with pt_x/pt_y held.
- Mid-search reset: pulse rst_n=0 during SAMPLE. gen_init and busy fall asynchronously; the next req goes through ARM and reseeds with the current seed_cnt.
